// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the HI/LO sequencing controller: instruction encodings
// on op_code, FSM state type, stall/divider handshake levels and the zero word.
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

    // op_code encodings presented by EX decode (6 and 7 mean "no HI/LO op")
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_BUSY = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    localparam logic STOP             = 1'b1;
    localparam logic NO_STOP          = 1'b0;
    localparam logic DIV_START        = 1'b1;
    localparam logic DIV_STOP         = 1'b0;
    localparam logic DIV_RESULT_READY = 1'b1;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Shared cycle counter width; wide enough for MUL_LAT and DIV_MAX.
    localparam int CNT_W = 8;

    // MULT and DIV are the signed flavours; MULTU and DIVU are unsigned.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO for the EX stage. Starts the external
// pipelined multiplier or iterative divider from latched operands, stalls EX
// until the result is ready, then writes HI/LO. Handles flush, divide-by-zero
// and a divider watchdog.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   op_valid_i, op_code_i             HI/LO-class instruction from EX (held while stalled)
//   src_a_i, src_b_i                  rs / rt operands
//   flush_i                           kill the in-flight op
//   stallreq_o                        stall request to the stall controller
//   mul_signed_o, mul_ina_o/inb_o     multiplier operands (from latches)
//   mul_result_i                      multiplier product
//   div_start_o, div_signed_o,
//   div_opa_o/opb_o, div_annul_o      divider control and operands (from latches)
//   div_ready_i, div_result_i         divider handshake, {remainder, quotient}
//   hi_we_o, lo_we_o,
//   hi_wdata_o, lo_wdata_o            HI/LO write port
//   div_timeout_o                     sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_MAX = 40
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        op_valid_i,
    input  logic [2:0]  op_code_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_ina_o,
    output logic [31:0] mul_inb_o,
    input  logic [63:0] mul_result_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_opa_o,
    output logic [31:0] div_opb_o,
    output logic        div_annul_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        hi_we_o,
    output logic        lo_we_o,
    output logic [31:0] hi_wdata_o,
    output logic [31:0] lo_wdata_o,
    output logic        div_timeout_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        opa_q, opa_d;
    logic [31:0]        opb_q, opb_d;
    logic               sgn_q, sgn_d;
    logic               tmo_q, tmo_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opa_q   <= ZERO_WORD;
            opb_q   <= ZERO_WORD;
            sgn_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sgn_q   <= sgn_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sgn_d       = sgn_q;
        tmo_d       = tmo_q;
        stallreq_o  = NO_STOP;
        div_start_o = DIV_STOP;
        div_annul_o = 1'b0;
        hi_we_o     = 1'b0;
        lo_we_o     = 1'b0;
        hi_wdata_o  = ZERO_WORD;
        lo_wdata_o  = ZERO_WORD;

        unique case (state_q)
            ST_IDLE: begin
                // A flush kills whatever EX presents this cycle.
                if (op_valid_i && !flush_i) begin
                    unique case (op_code_i)
                        OP_MULT, OP_MULTU: begin
                            opa_d      = src_a_i;
                            opb_d      = src_b_i;
                            sgn_d      = is_signed_op(op_code_i);
                            cnt_d      = CNT_W'(1);
                            stallreq_o = STOP;
                            state_d    = ST_MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (src_b_i == ZERO_WORD) begin
                                // Divide-by-zero completes at once: HI = dividend, LO = all ones.
                                hi_we_o    = 1'b1;
                                lo_we_o    = 1'b1;
                                hi_wdata_o = src_a_i;
                                lo_wdata_o = '1;
                                state_d    = ST_DONE;
                            end else begin
                                // The divider is started from the latches in DIV_BUSY,
                                // so it never sees operands that are not yet latched.
                                opa_d      = src_a_i;
                                opb_d      = src_b_i;
                                sgn_d      = is_signed_op(op_code_i);
                                cnt_d      = CNT_W'(1);
                                stallreq_o = STOP;
                                state_d    = ST_DIV_BUSY;
                            end
                        end
                        OP_MTHI: begin
                            hi_we_o    = 1'b1;
                            hi_wdata_o = src_a_i;
                        end
                        OP_MTLO: begin
                            lo_we_o    = 1'b1;
                            lo_wdata_o = src_a_i;
                        end
                        default: ;
                    endcase
                end
            end

            ST_MUL_WAIT: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(MUL_LAT)) begin
                    hi_we_o    = 1'b1;
                    lo_we_o    = 1'b1;
                    hi_wdata_o = mul_result_i[63:32];
                    lo_wdata_o = mul_result_i[31:0];
                    state_d    = ST_DONE;
                end else begin
                    stallreq_o = STOP;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end

            ST_DIV_BUSY: begin
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    state_d     = ST_IDLE;
                end else if (div_ready_i == DIV_RESULT_READY) begin
                    // Checked before the watchdog so a result on the last cycle is kept.
                    hi_we_o    = 1'b1;
                    lo_we_o    = 1'b1;
                    hi_wdata_o = div_result_i[63:32];
                    lo_wdata_o = div_result_i[31:0];
                    state_d    = ST_DONE;
                end else if (cnt_q == CNT_W'(DIV_MAX)) begin
                    div_annul_o = 1'b1;
                    tmo_d       = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    div_start_o = DIV_START;
                    stallreq_o  = STOP;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end

            // One dead cycle while EX still holds the completed instruction,
            // so a held op_valid is not accepted a second time.
            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // The flag is visible in the same cycle the watchdog fires.
    assign div_timeout_o = tmo_d;

    assign mul_signed_o = sgn_q;
    assign mul_ina_o    = opa_q;
    assign mul_inb_o    = opb_q;
    assign div_signed_o = sgn_q;
    assign div_opa_o    = opa_q;
    assign div_opb_o    = opb_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencing controller for the EX-stage HI/LO arithmetic resources. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, starts the pipelined multiplier or the iterative divider, and raises the EX stall request until the result is ready. It then writes HI/LO and handles flush and divide-by-zero. It sits between EX decode and the existing `mul`/`div` units and owns the HI/LO write port.

Parameters:
MUL_LAT, 2, cycles from `mul` operand presentation to valid `mul_result` (1..7)
DIV_MAX, 40, watchdog bound in cycles for the divider handshake

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
op_valid  in  1  EX holds a HI/LO-class instruction (held stable while stalled)
op_code  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others = none
src_a  in  32  rs operand
src_b  in  32  rt operand
flush  in  1  kill the in-flight op
stallreq  out  1  to stall controller; Stop = 1
mul_signed  out  1  to `mul`
mul_ina  out  32  to `mul`
mul_inb  out  32  to `mul`
mul_result  in  64  from `mul`
div_start  out  1  to `div` start_i
div_signed  out  1  to `div`
div_opa  out  32  to `div`
div_opb  out  32  to `div`
div_annul  out  1  to `div` annul_i
div_ready  in  1  from `div` ready_o
div_result  in  64  from `div`, {remainder, quotient}
hi_we  out  1  HI write strobe
lo_we  out  1  LO write strobe
hi_wdata  out  32  HI write data
lo_wdata  out  32  LO write data
div_timeout  out  1  sticky error flag, cleared only by rst

Behaviour:
- States: IDLE, MUL_WAIT, DIV_BUSY, DONE. Reset gives state IDLE, counter 0, div_timeout 0, and all outputs 0.
- Operand latching: operands are latched into internal registers on acceptance. mul_ina/inb and div_opa/opb are driven from these latches, not from src_a/src_b.
- IDLE, MULT/MULTU: latch operands and go to MUL_WAIT with counter = 1. stallreq is 1 combinationally in the acceptance cycle.
- MUL_WAIT: counter increments each cycle. When counter == MUL_LAT, hi_we = lo_we = 1 with {hi_wdata, lo_wdata} = mul_result, stallreq = 0, and the next state is DONE. Total stall is MUL_LAT cycles.
- IDLE, DIV/DIVU with src_b != 0: latch operands, assert div_start, go to DIV_BUSY. div_start stays 1 until div_ready. stallreq = 1.
- IDLE, DIV/DIVU with src_b == 0: no divider start. In the same cycle, hi_we = lo_we = 1, HI = src_a, LO = 32'hFFFF_FFFF, stallreq = 0. Next state is DONE.
- DIV_BUSY: when div_ready = 1, write HI = div_result[63:32] and LO = div_result[31:0], drop div_start, set stallreq = 0, go to DONE.
- DIV_BUSY watchdog: if the counter reaches DIV_MAX first, assert div_annul for 1 cycle, set div_timeout, write nothing, release the stall and go to DONE.
- DONE: one cycle while EX still presents the same instruction. No new acceptance, stallreq = 0, then IDLE. This prevents re-issue of a held op_valid.
- MTHI/MTLO in IDLE: hi_we or lo_we = 1 in the same cycle with data src_a. No stall, state stays IDLE.
- flush (highest priority, any state): next state IDLE and no HI/LO write that cycle. If in DIV_BUSY, div_annul = 1 for that cycle and div_start = 0. A flush in IDLE also suppresses MTHI/MTLO and acceptance.
- Simultaneous div_ready and watchdog expiry: div_ready wins.
- Reset mid-operation: immediate IDLE; the divider is reset through its own rst, so no annul is needed.
- hi_we/lo_we are never 1 in two consecutive cycles for the same instruction.

Decomposition:
- Shared package `defines.vh`: op_code encodings, state encodings, `Stop`/`NoStop`, `DivStart`/`DivStop`, `DivResultReady`/`DivResultNotReady`, `ZeroWord`.
- No sub-module. The FSM, counter and operand latches live in one module; `mul` and `div` are instantiated by the parent EX.

Test Plan:
- MULTU a=32'hFFFF_FFFF, b=2, MUL_LAT=2 -> stallreq 1 for 2 cycles; hi_we/lo_we pulse with HI=1, LO=32'hFFFF_FFFE; next cycle DONE, no rewrite.
- MULT a=-3, b=5 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF1 after MUL_LAT cycles.
- DIV a=-7, b=2, model divider ready after 34 cycles -> stallreq 1 for 34 cycles; LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; div_start drops with ready.
- DIVU a=9, b=0 -> no div_start; same-cycle write HI=9, LO=32'hFFFF_FFFF; stallreq never 1.
- DIV in progress, flush at cycle 10 -> div_annul pulse, no hi_we/lo_we, IDLE next; a following MTLO a=5 writes LO=5 with no stall.
- Divider model never readies, DIV_MAX=40 -> div_annul and div_timeout set at cycle 40, stall released, div_timeout stays 1 until rst.
